// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Holds the data/address widths and the write-source encodings so the hazard
// unit and benches decode wb_src the same way the arbiter drives it.
package wb_port_arbiter_pkg;

    localparam int unsigned DW = 128;  // write-back data width
    localparam int unsigned AW = 5;    // register address width

    // wb_src / mux_sel encodings
    localparam logic SRC_A = 1'b0;     // ALU result
    localparam logic SRC_B = 1'b1;     // load data

endpackage

// File: rtl/mux128.sv
// Existing 128-bit 2:1 datapath mux.
// Ports:
//   ina  - input selected when sel=0
//   inb  - input selected when sel=1
//   sel  - select
//   out  - selected data
module mux128 (
    input  logic [0:127] ina,
    input  logic [0:127] inb,
    input  logic         sel,
    output logic [0:127] out
);

    assign out = sel ? inb : ina;

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the single register-file write port between
// producer A (ALU) and producer B (load data), and registers the winner into a
// one-deep valid/ready output stage.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   a_valid/addr/data     - producer A request;  a_ready - A accepted this cycle
//   b_valid/addr/data     - producer B request;  b_ready - B accepted this cycle
//   mux_sel               - combinational select into the mux128 (0=A, 1=B)
//   wb_valid/ready        - output stage handshake toward the register file
//   wb_addr/data/src      - held write: address, data, source (0=A, 1=B)
//   conflict_cnt          - saturating count of cycles where one request was refused
module wb_port_arbiter #(
    parameter int unsigned DW         = wb_port_arbiter_pkg::DW,
    parameter int unsigned AW         = wb_port_arbiter_pkg::AW,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [0:AW-1] a_addr,
    input  logic [0:DW-1] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [0:AW-1] b_addr,
    input  logic [0:DW-1] b_data,
    output logic          b_ready,
    output logic          mux_sel,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [0:AW-1] wb_addr,
    output logic [0:DW-1] wb_data,
    output logic          wb_src,
    output logic [CW-1:0] conflict_cnt
);

    import wb_port_arbiter_pkg::*;

    logic          w_load;
    logic          w_pick_b;
    logic          w_a_ready;
    logic          w_b_ready;
    logic          w_accept;
    logic          w_conflict;
    logic [0:DW-1] w_mux_data;

    logic          r_wb_valid;
    logic          r_wb_src;
    logic [0:AW-1] r_wb_addr;
    logic [0:DW-1] r_wb_data;
    logic          r_last_grant;
    logic [CW-1:0] r_conflict_cnt;

    // Output stage can take new data when empty or draining this cycle.
    assign w_load = !r_wb_valid || wb_ready;

    always_comb begin
        w_pick_b = SRC_A;
        if (b_valid && !a_valid) begin
            w_pick_b = SRC_B;
        end else if (a_valid && b_valid && FIXED_PRIO == 0) begin
            // Round-robin: the side that did not win the last grant wins the tie.
            w_pick_b = !r_last_grant;
        end
    end

    // Readies are held low under reset so no producer thinks it was consumed.
    assign w_a_ready  = !rst && w_load && a_valid && !w_pick_b;
    assign w_b_ready  = !rst && w_load && b_valid && w_pick_b;
    assign w_accept   = w_a_ready || w_b_ready;
    assign w_conflict = a_valid && b_valid && w_load;

    mux128 u_mux128 (
        .ina (a_data),
        .inb (b_data),
        .sel (w_pick_b),
        .out (w_mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_src       <= SRC_A;
            r_wb_addr      <= '0;
            r_wb_data      <= '0;
            r_last_grant   <= SRC_B;  // so A wins the first tie
            r_conflict_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wb_valid   <= 1'b1;
                r_wb_src     <= w_pick_b;
                r_wb_addr    <= w_pick_b ? b_addr : a_addr;
                r_wb_data    <= w_mux_data;
                r_last_grant <= w_pick_b;
            end else if (w_load) begin
                r_wb_valid <= 1'b0;
            end
            if (w_conflict && r_conflict_cnt != {CW{1'b1}}) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign a_ready      = w_a_ready;
    assign b_ready      = w_b_ready;
    assign mux_sel      = w_pick_b;
    assign wb_valid     = r_wb_valid;
    assign wb_addr      = r_wb_addr;
    assign wb_data      = r_wb_data;
    assign wb_src       = r_wb_src;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: three instances (round-robin, fixed priority,
// round-robin with a 2-bit counter) share one stimulus stream. A reference
// model per instance pushes each expected write into a scoreboard queue on
// accept; the held write on wb_* is compared against the queue head.
module tb_wb_port_arbiter;

    import wb_port_arbiter_pkg::*;

    typedef struct packed {
        logic          src;
        logic [0:AW-1] addr;
        logic [0:DW-1] data;
    } wb_item_t;

    logic          clk;
    logic          rst;
    logic          a_valid;
    logic [0:AW-1] a_addr;
    logic [0:DW-1] a_data;
    logic          b_valid;
    logic [0:AW-1] b_addr;
    logic [0:DW-1] b_data;
    logic          wb_ready;

    logic [2:0]    dut_a_rdy;
    logic [2:0]    dut_b_rdy;
    logic [2:0]    dut_sel;
    logic [2:0]    dut_wbv;
    logic [2:0]    dut_src;
    logic [0:AW-1] dut_addr [3];
    logic [0:DW-1] dut_data [3];
    logic [15:0]   cnt_rr;
    logic [15:0]   cnt_fp;
    logic [1:0]    cnt_sat;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_fp  [3] = '{1'b0, 1'b1, 1'b0};
    int       m_max [3] = '{65535, 65535, 3};
    logic     m_wbv [3] = '{1'b0, 1'b0, 1'b0};
    logic     m_lg  [3] = '{1'b1, 1'b1, 1'b1};
    int       m_cnt [3] = '{0, 0, 0};
    wb_item_t exp_q [3][$];
    bit       started = 1'b0;

    wb_port_arbiter #(.FIXED_PRIO(0), .CW(16)) u_rr (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(dut_a_rdy[0]),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(dut_b_rdy[0]),
        .mux_sel(dut_sel[0]), .wb_valid(dut_wbv[0]), .wb_ready(wb_ready),
        .wb_addr(dut_addr[0]), .wb_data(dut_data[0]), .wb_src(dut_src[0]),
        .conflict_cnt(cnt_rr)
    );

    wb_port_arbiter #(.FIXED_PRIO(1), .CW(16)) u_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(dut_a_rdy[1]),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(dut_b_rdy[1]),
        .mux_sel(dut_sel[1]), .wb_valid(dut_wbv[1]), .wb_ready(wb_ready),
        .wb_addr(dut_addr[1]), .wb_data(dut_data[1]), .wb_src(dut_src[1]),
        .conflict_cnt(cnt_fp)
    );

    wb_port_arbiter #(.FIXED_PRIO(0), .CW(2)) u_sat (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(dut_a_rdy[2]),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(dut_b_rdy[2]),
        .mux_sel(dut_sel[2]), .wb_valid(dut_wbv[2]), .wb_ready(wb_ready),
        .wb_addr(dut_addr[2]), .wb_data(dut_data[2]), .wb_src(dut_src[2]),
        .conflict_cnt(cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_pick(input int i);
        if (b_valid && !a_valid) return 1'b1;
        if (a_valid && b_valid) return m_fp[i] ? 1'b0 : !m_lg[i];
        return 1'b0;
    endfunction

    function automatic logic [15:0] dut_cnt(input int i);
        if (i == 0) return cnt_rr;
        if (i == 1) return cnt_fp;
        return {14'b0, cnt_sat};
    endfunction

    // Reference model: advances on the same edge as the DUTs.
    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic ld;
            logic pb;
            logic acc;
            wb_item_t it;
            if (rst) begin
                m_wbv[i] <= 1'b0;
                m_lg[i]  <= 1'b1;
                m_cnt[i] <= 0;
                exp_q[i].delete();
            end else begin
                ld  = !m_wbv[i] || wb_ready;
                pb  = model_pick(i);
                acc = ld && ((a_valid && !pb) || (b_valid && pb));
                if (m_wbv[i] && wb_ready && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
                if (acc) begin
                    it.src  = pb;
                    it.addr = pb ? b_addr : a_addr;
                    it.data = pb ? b_data : a_data;
                    exp_q[i].push_back(it);
                    m_wbv[i] <= 1'b1;
                    m_lg[i]  <= pb;
                end else if (ld) begin
                    m_wbv[i] <= 1'b0;
                end
                if (a_valid && b_valid && ld && m_cnt[i] != m_max[i]) m_cnt[i] <= m_cnt[i] + 1;
            end
        end
    end

    // Monitor: compare every instance against its model on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic ld;
                logic pb;
                wb_item_t got;
                ld = !m_wbv[i] || wb_ready;
                pb = model_pick(i);
                check_val($sformatf("a_ready%0d", i), dut_a_rdy[i],
                          !rst && ld && a_valid && !pb);
                check_val($sformatf("b_ready%0d", i), dut_b_rdy[i],
                          !rst && ld && b_valid && pb);
                check_val($sformatf("mux_sel%0d", i), dut_sel[i], pb);
                check_val($sformatf("wb_valid%0d", i), dut_wbv[i], m_wbv[i]);
                check_val($sformatf("cnt%0d", i), dut_cnt(i), m_cnt[i]);
                if (m_wbv[i]) begin
                    got = '{src: dut_src[i], addr: dut_addr[i], data: dut_data[i]};
                    if (exp_q[i].size() == 0) begin
                        check_val($sformatf("sb_empty%0d", i), got, {134{1'bx}});
                    end else begin
                        check_val($sformatf("item%0d", i), got, exp_q[i][0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic after_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [0:DW-1] ones;
        ones = {32{4'h1}};

        // Reset with both producers requesting
        rst = 1'b1; wb_ready = 1'b1;
        a_valid = 1'b1; a_addr = 5'd1; a_data = '1;
        b_valid = 1'b1; b_addr = 5'd2; b_data = ones;
        step();
        check_val("rst_a_ready", dut_a_rdy[0], 1'b0);
        check_val("rst_b_ready", dut_b_rdy[0], 1'b0);
        step();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check_val("post_rst_wb_valid", dut_wbv[0], 1'b0);
        check_val("post_rst_cnt", cnt_rr, 16'd0);
        #1;

        // A only
        a_valid = 1'b1; a_addr = 5'd3; a_data = '0;
        step();
        a_valid = 1'b0;
        @(negedge clk);
        check_val("aonly_valid", dut_wbv[0], 1'b1);
        check_val("aonly_addr", dut_addr[0], 5'd3);
        check_val("aonly_data", dut_data[0], {DW{1'b0}});
        check_val("aonly_src", dut_src[0], SRC_A);
        #1;

        // Round-robin vs fixed priority, 4 conflict cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = {$urandom, $urandom, $urandom, $urandom};
        b_valid = 1'b1; b_addr = 5'd9; b_data = ones;
        for (int k = 0; k < 4; k++) begin
            step();
            a_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_val($sformatf("rr_src%0d", k), dut_src[0], (k % 2 == 1) ? SRC_B : SRC_A);
            check_val($sformatf("fp_src%0d", k), dut_src[1], SRC_A);
            check_val($sformatf("fp_b_ready%0d", k), dut_b_rdy[1], 1'b0);
        end
        check_val("rr_cnt4", cnt_rr, 16'd4);
        check_val("sat_cnt", cnt_sat, 2'd3);
        #1;

        // Stall: hold the last B write while both keep requesting
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("stall_a_ready%0d", k), dut_a_rdy[0], 1'b0);
            check_val($sformatf("stall_b_ready%0d", k), dut_b_rdy[0], 1'b0);
            check_val($sformatf("stall_src%0d", k), dut_src[0], SRC_B);
            check_val($sformatf("stall_addr%0d", k), dut_addr[0], 5'd9);
            check_val($sformatf("stall_data%0d", k), dut_data[0], ones);
        end
        #1;
        wb_ready = 1'b1;
        #1;
        check_val("release_a_ready", dut_a_rdy[0], 1'b1);
        check_val("release_b_ready", dut_b_rdy[0], 1'b0);
        @(negedge clk);
        check_val("release_src", dut_src[0], SRC_A);
        check_val("release_addr", dut_addr[0], 5'd7);
        check_val("rr_cnt5", cnt_rr, 16'd5);
        check_val("sat_hold", cnt_sat, 2'd3);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;

        // Random traffic with back-pressure and occasional mid-operation reset
        for (int k = 0; k < 400; k++) begin
            step();
            rst      = ($urandom_range(0, 49) == 0);
            a_valid  = $urandom_range(0, 1) == 1;
            b_valid  = $urandom_range(0, 1) == 1;
            wb_ready = $urandom_range(0, 3) != 0;
            a_addr   = AW'($urandom);
            b_addr   = AW'($urandom);
            a_data   = {$urandom, $urandom, $urandom, $urandom};
            b_data   = {$urandom, $urandom, $urandom, $urandom};
        end
        step();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; wb_ready = 1'b1;
        repeat (3) step();
        after_neg();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single 128-bit register-file write-back port between two producers: A (ALU result) and B (load data).
- Arbitrates between them and drives the select of the existing mux128 2:1 datapath mux: sel=0 picks A, sel=1 picks B.
- Registers the winning result into a one-deep output stage with a valid/ready handshake toward the register file.
- Sits between the execute/memory stages and the register-file write port.

Parameters:
- DW, 128, data width. All data buses are bit-ordered [0:DW-1], bit 0 is the MSB.
- AW, 5, register-address width, ordered [0:AW-1].
- FIXED_PRIO, 0. 0 selects round-robin; 1 makes A always win.
- CW, 16, width of the conflict counter.

Ports:
- clk  in  1  clock. Single clock domain; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  producer A has a result.
- a_addr  in  AW  destination register for A.
- a_data  in  DW  result data for A.
- a_ready  out  1  A's result is accepted this cycle.
- b_valid  in  1  producer B has a result.
- b_addr  in  AW  destination register for B.
- b_data  in  DW  result data for B.
- b_ready  out  1  B's result is accepted this cycle.
- mux_sel  out  1  combinational select into the mux128 instance.
- wb_valid  out  1  output stage holds a write.
- wb_ready  in  1  register file consumes the write this cycle.
- wb_addr  out  AW  write address.
- wb_data  out  DW  write data.
- wb_src  out  1  source of the held write: 0=A, 1=B.
- conflict_cnt  out  CW  number of cycles in which both producers requested and one was refused.

Behaviour:
- Reset values: wb_valid=0, wb_addr=0, wb_data=0, wb_src=0, conflict_cnt=0, last_grant=1 (so A wins the first tie). rst overrides all other inputs in the same cycle.
- load = !wb_valid | wb_ready. The output stage accepts new data only when it is empty or is being drained in the same cycle.
- pick_b is combinational:
  - b_valid & !a_valid -> 1
  - a_valid & !b_valid -> 0
  - both valid, FIXED_PRIO=1 -> 0
  - both valid, FIXED_PRIO=0 -> !last_grant (alternates)
  - neither valid -> 0
- mux_sel = pick_b.
- a_ready = load & a_valid & !pick_b.
- b_ready = load & b_valid & pick_b.
- At most one ready is high in any cycle.
- On accept (a_ready|b_ready) at the clock edge:
  - wb_data <= mux128 output, wb_addr <= selected address, wb_src <= pick_b, wb_valid <= 1, last_grant <= pick_b.
- If load is high with no accept: wb_valid <= 0. The other output-stage fields hold their values.
- If load is low: the output stage and last_grant hold. This is a stall; both readies stay 0 and producers must hold their inputs.
- Latency: an accepted result appears on wb_* on the next cycle. Throughput is 1 write per cycle while wb_ready stays high.
- Conflict counting: conflict_cnt increments when a_valid & b_valid & load. It saturates at all-ones and does not wrap.
- Same-address conflicts between A and B are not detected. Program order is whatever the arbitration order yields; upstream hazard logic owns correctness.
- Mid-operation reset: a write held in the output stage is dropped (wb_valid=0 next cycle). Producers must re-present their results.
- Producer inputs are sampled only when the corresponding ready is high. A valid may drop without being accepted; no deadlock results.

Decomposition:
- Shared package holds DW, AW, and the source encodings SRC_A=0 and SRC_B=1 for reuse by the hazard unit and by benches.
- The data path reuses the existing mux128 as one instance, with ina=a_data, inb=b_data, sel=mux_sel. There is no new sub-module.
- Arbitration, the output register and the counter live in this module.

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0 during reset, and wb_valid=0, conflict_cnt=0 after it.
- A only: a_valid=1, a_addr=5'd3, a_data=128'h0000…0000, wb_ready=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=all zero, wb_src=0.
- Round-robin: both valid for 4 cycles, b_data=128'h1111…1111, wb_ready=1 -> wb_src sequence 0,1,0,1 and conflict_cnt=4.
- Stall: wb_valid=1, wb_ready=0 for 3 cycles with both valid -> a_ready=b_ready=0 and wb_* constant. When wb_ready returns to 1, the next winner is loaded the same cycle.
- FIXED_PRIO=1: both valid for 3 cycles -> wb_src=0,0,0 and b_ready stays 0.
- Saturation (CW=2): 5 conflict cycles -> conflict_cnt reads 3 and holds at 3.
